pacman_move_scheduler: RTL and testbench

//  Initiator side of the sprite-animator go/done handshake. Frame-rate tick issues one move request per frame.

---
 rtl/pacman_move_scheduler_pkg.sv | 17 +
 rtl/pacman_move_scheduler_frame_tick_gen.sv | 29 ++
 rtl/pacman_move_scheduler.sv | 157 +++++++++++++++
 tb/tb_pacman_move_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_move_scheduler_pkg.sv
// Shared constants and FSM encoding for the pacman move scheduler.
package pacman_move_scheduler_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned SPR_W_DEF = 20;
  localparam int unsigned SPR_H_DEF = 20;

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StGo,
    StWaitDone,
    StLatch
  } state_e;

endpackage

// File: rtl/pacman_move_scheduler_frame_tick_gen.sv
// Free-running frame divider; o_tick is high for the single wrap cycle of the counter.
module pacman_move_scheduler_frame_tick_gen #(
  parameter int unsigned FRAME_DIV = 833333
) (
  input  logic i_clock,
  input  logic i_resetn,
  output logic o_tick
);

  localparam int unsigned CntW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntW'(FRAME_DIV - 1));

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = w_wrap;

endmodule

// File: rtl/pacman_move_scheduler.sv
// Per-frame move sequencer: erases the sprite, hands off to the animator via go/done,
// then accepts or rejects the returned position.
module pacman_move_scheduler
  import pacman_move_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_DIV = 833333,
  parameter logic [7:0]  START_X   = 8'd70,
  parameter logic [6:0]  START_Y   = 7'd50,
  parameter int unsigned SPR_W     = SPR_W_DEF,
  parameter int unsigned SPR_H     = SPR_H_DEF,
  parameter logic [7:0]  MAX_X     = 8'(SCREEN_W - SPR_W_DEF),
  parameter logic [6:0]  MAX_Y     = 7'(SCREEN_H - SPR_H_DEF),
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic       i_clock,
  input  logic       i_resetn,
  input  logic       i_win,
  output logic       o_go,
  input  logic       i_done,
  output logic [7:0] o_pos_x,
  output logic [6:0] o_pos_y,
  input  logic [7:0] i_new_x,
  input  logic [6:0] i_new_y,
  output logic [7:0] o_erase_x,
  output logic [6:0] o_erase_y,
  output logic [2:0] o_erase_col,
  output logic       o_erase_we,
  output logic       o_draw_sel,
  output logic       o_timeout
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  logic             w_tick;
  state_e           r_state, w_state_d;
  logic             r_pending, w_pending_d;
  logic [7:0]       r_ex, w_ex_d;
  logic [6:0]       r_ey, w_ey_d;
  logic [WaitW-1:0] r_wait, w_wait_d;
  logic [7:0]       r_pos_x, w_pos_x_d;
  logic [6:0]       r_pos_y, w_pos_y_d;
  logic             r_timeout, w_timeout_d;
  logic             r_go, r_erase_we, r_draw_sel;
  logic [7:0]       r_erase_x;
  logic [6:0]       r_erase_y;

  pacman_move_scheduler_frame_tick_gen #(
    .FRAME_DIV(FRAME_DIV)
  ) u_tick (
    .i_clock (i_clock),
    .i_resetn(i_resetn),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_d   = r_state;
    w_pending_d = r_pending;
    w_ex_d      = r_ex;
    w_ey_d      = r_ey;
    w_wait_d    = r_wait;
    w_pos_x_d   = r_pos_x;
    w_pos_y_d   = r_pos_y;
    w_timeout_d = r_timeout;
    unique case (r_state)
      StIdle: begin
        if (r_pending && !i_win) begin
          w_state_d   = StErase;
          w_pending_d = 1'b0;
          w_ex_d      = '0;
          w_ey_d      = '0;
        end
      end
      StErase: begin
        if (r_ex == 8'(SPR_W - 1)) begin
          w_ex_d = '0;
          if (r_ey == 7'(SPR_H - 1)) begin
            w_state_d = StGo;
          end else begin
            w_ey_d = r_ey + 7'd1;
          end
        end else begin
          w_ex_d = r_ex + 8'd1;
        end
      end
      StGo: begin
        w_state_d = StWaitDone;
        w_wait_d  = '0;
      end
      StWaitDone: begin
        if (i_done) begin
          w_state_d = StLatch;
        end else if (r_wait == WaitW'(TIMEOUT)) begin
          w_timeout_d = 1'b1;
          w_state_d   = StIdle;
        end else begin
          w_wait_d = r_wait + 1'b1;
        end
      end
      StLatch: begin
        // Out-of-range covers both overshoot and wrap-around from a negative step.
        if (i_new_x <= MAX_X && i_new_y <= MAX_Y) begin
          w_pos_x_d = i_new_x;
          w_pos_y_d = i_new_y;
        end
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // A fresh tick wins over consumption; only one request is ever held.
    if (w_tick) begin
      w_pending_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state    <= StIdle;
      r_pending  <= 1'b0;
      r_ex       <= '0;
      r_ey       <= '0;
      r_wait     <= '0;
      r_pos_x    <= START_X;
      r_pos_y    <= START_Y;
      r_timeout  <= 1'b0;
      r_go       <= 1'b0;
      r_erase_we <= 1'b0;
      r_draw_sel <= 1'b0;
      r_erase_x  <= '0;
      r_erase_y  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_pending  <= w_pending_d;
      r_ex       <= w_ex_d;
      r_ey       <= w_ey_d;
      r_wait     <= w_wait_d;
      r_pos_x    <= w_pos_x_d;
      r_pos_y    <= w_pos_y_d;
      r_timeout  <= w_timeout_d;
      r_go       <= (w_state_d == StGo);
      r_erase_we <= (w_state_d == StErase);
      r_draw_sel <= (w_state_d == StErase);
      r_erase_x  <= w_pos_x_d + w_ex_d;
      r_erase_y  <= w_pos_y_d + w_ey_d;
    end
  end

  assign o_go        = r_go;
  assign o_pos_x     = r_pos_x;
  assign o_pos_y     = r_pos_y;
  assign o_erase_x   = r_erase_x;
  assign o_erase_y   = r_erase_y;
  assign o_erase_col = 3'b000;
  assign o_erase_we  = r_erase_we;
  assign o_draw_sel  = r_draw_sel;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_pacman_move_scheduler.sv
// Bench for pacman_move_scheduler: phase-count reference model, scripted scenarios,
// then randomized traffic with a go/done responder.
module tb_pacman_move_scheduler;

  localparam int FD = 16;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int TO = 8;
  localparam logic [7:0] MAXX = 8'd100;
  localparam logic [6:0] MAXY = 7'd100;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       win = 1'b0;
  logic       done = 1'b0;
  logic [7:0] new_x = '0;
  logic [6:0] new_y = '0;
  logic       o_go, o_erase_we, o_draw_sel, o_timeout;
  logic [7:0] o_pos_x, o_erase_x;
  logic [6:0] o_pos_y, o_erase_y;
  logic [2:0] o_erase_col;

  pacman_move_scheduler #(
    .FRAME_DIV(FD), .START_X(8'd70), .START_Y(7'd50), .SPR_W(W), .SPR_H(H),
    .MAX_X(MAXX), .MAX_Y(MAXY), .TIMEOUT(TO)
  ) dut (
    .i_clock(clk), .i_resetn(resetn), .i_win(win), .o_go(o_go), .i_done(done),
    .o_pos_x(o_pos_x), .o_pos_y(o_pos_y), .i_new_x(new_x), .i_new_y(new_y),
    .o_erase_x(o_erase_x), .o_erase_y(o_erase_y), .o_erase_col(o_erase_col),
    .o_erase_we(o_erase_we), .o_draw_sel(o_draw_sel), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: phase -1 idle, 0..N-1 erase pixel index, N go, N+1 waiting, N+2 latch.
  int m_cnt = 0, m_phase = -1, m_wait = 0, m_px = 70, m_py = 50;
  bit m_pend = 0, m_to = 0;

  // Responder / stats
  int cd = -1, mode = 0, cyc = 0;
  bit spur = 0;
  int st_we = 0, st_go = 0, mnx = 999, mxx = -1, mny = 999, mxy = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit tick, consume;
    if (!resetn) begin
      m_cnt = 0; m_phase = -1; m_pend = 0; m_px = 70; m_py = 50; m_to = 0; m_wait = 0;
    end else begin
      tick = (m_cnt == FD - 1);
      m_cnt = (m_cnt + 1) % FD;
      consume = 0;
      if (m_phase < 0) begin
        if (m_pend && !win) begin m_phase = 0; consume = 1; end
      end else if (m_phase < N) begin
        m_phase++;
      end else if (m_phase == N) begin
        m_phase = N + 1; m_wait = 0;
      end else if (m_phase == N + 1) begin
        if (done) m_phase = N + 2;
        else if (m_wait == TO) begin m_to = 1; m_phase = -1; end
        else m_wait++;
      end else begin
        if (new_x <= MAXX && new_y <= MAXY) begin m_px = int'(new_x); m_py = int'(new_y); end
        m_phase = -1;
      end
      m_pend = tick || (m_pend && !consume);
    end
  endtask

  task automatic cycle();
    bit ewe;
    int r;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    ewe = (m_phase >= 0 && m_phase < N);
    chk("go", o_go, 32'(m_phase == N));
    chk("erase_we", o_erase_we, 32'(ewe));
    chk("draw_sel", o_draw_sel, 32'(ewe));
    chk("erase_col", o_erase_col, 0);
    chk("pos_x", o_pos_x, m_px);
    chk("pos_y", o_pos_y, m_py);
    chk("timeout", o_timeout, 32'(m_to));
    if (ewe) begin
      chk("erase_x", o_erase_x, (m_px + m_phase % W) % 256);
      chk("erase_y", o_erase_y, (m_py + m_phase / W) % 128);
    end
    if (o_erase_we) begin
      st_we++;
      if (int'(o_erase_x) < mnx) mnx = int'(o_erase_x);
      if (int'(o_erase_x) > mxx) mxx = int'(o_erase_x);
      if (int'(o_erase_y) < mny) mny = int'(o_erase_y);
      if (int'(o_erase_y) > mxy) mxy = int'(o_erase_y);
    end
    if (o_go) st_go++;
    if (!resetn) cd = -1;
    if (m_phase == N) begin
      cd = -1;
      case (mode)
        0: begin new_x = 8'(m_px + 3); new_y = 7'(m_py); cd = 1; end
        1: begin new_x = 8'd253; new_y = 7'(m_py); cd = 1; end
        2: cd = -1;
        default: begin
          r = $urandom_range(0, 3);
          new_x = 8'(m_px); new_y = 7'(m_py);
          if (r == 0) new_x = 8'(m_px + 3);
          else if (r == 1) new_x = 8'(m_px - 3);
          else if (r == 2) new_y = 7'(m_py + 3);
          else begin new_x = 8'($urandom); new_y = 7'($urandom); end
          cd = $urandom_range(0, 10) + 1;
        end
      endcase
    end
    done = 1'b0;
    if (cd >= 0) begin
      done = (cd == 0);
      cd--;
    end else if (spur && m_phase < N && $urandom_range(0, 15) == 0) begin
      done = 1'b1;
    end
  endtask

  task automatic clr_stats();
    st_we = 0; st_go = 0; mnx = 999; mxx = -1; mny = 999; mxy = -1;
  endtask

  task automatic run_until_go(input int budget, input string nm);
    int k;
    k = 0;
    do begin cycle(); k++; end while (!o_go && k < budget);
    chk(nm, o_go, 1);
  endtask

  task automatic first_we_latency(input string nm, input int exp);
    int c0;
    c0 = cyc;
    do cycle(); while (!o_erase_we && cyc - c0 < 60);
    chk(nm, cyc - c0, exp);
  endtask

  initial begin
    int c0;
    resetn = 1'b0;
    repeat (3) cycle();
    chk("reset_pos_x", o_pos_x, 70);
    chk("reset_pos_y", o_pos_y, 50);
    chk("reset_we", o_erase_we, 0);
    resetn = 1'b1;
    clr_stats();
    c0 = cyc;
    // First move: tick at release+16, erase from +17, go at +33.
    first_we_latency("first_erase_latency", 17);
    run_until_go(40, "first_go_seen");
    chk("first_go_latency", cyc - c0, 33);
    chk("erase_count", st_we, 16);
    chk("erase_min_x", mnx, 70);
    chk("erase_max_x", mxx, 73);
    chk("erase_min_y", mny, 50);
    chk("erase_max_y", mxy, 53);
    repeat (3) cycle();
    mode = 1;
    chk("accept_pos_x", o_pos_x, 73);
    chk("accept_pos_y", o_pos_y, 50);

    run_until_go(60, "underflow_go");
    repeat (4) cycle();
    chk("underflow_keep_x", o_pos_x, 73);
    mode = 2;
    clr_stats();
    run_until_go(60, "timeout_go");
    chk("old_pos_erase_min_x", mnx, 73);
    chk("old_pos_erase_max_x", mxx, 76);
    repeat (9) cycle();
    chk("timeout_not_yet", o_timeout, 0);
    cycle();
    chk("timeout_set", o_timeout, 1);
    mode = 0;
    c0 = cyc;
    do cycle(); while (!o_erase_we && cyc - c0 < 40);
    chk("erase_after_timeout", o_erase_we, 1);

    win = 1'b1;
    repeat (40) cycle();
    clr_stats();
    repeat (50) cycle();
    chk("win_no_go", st_go, 0);
    win = 1'b0;
    clr_stats();
    repeat (25) cycle();
    chk("one_move_after_win", st_go, 1);
    chk("timeout_sticky", o_timeout, 1);

    c0 = cyc;
    do cycle(); while (!o_erase_we && cyc - c0 < 40);
    repeat (3) cycle();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    chk("midreset_we", o_erase_we, 0);
    chk("midreset_sel", o_draw_sel, 0);
    chk("midreset_pos_x", o_pos_x, 70);
    chk("midreset_pos_y", o_pos_y, 50);
    chk("midreset_timeout", o_timeout, 0);
    first_we_latency("restart_latency", 17);

    mode = 3;
    spur = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) win = ~win;
      resetn = ($urandom_range(0, 999) != 0);
      cycle();
    end
    resetn = 1'b1;
    win = 1'b0;
    repeat (5) cycle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
